// File: rtl/approx_eval_pkg.sv
// Shared types and sizing helpers for the approximate-circuit evaluation blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package approx_eval_pkg;

   // Default circuit geometry and error threshold for the sweeper.
   localparam int DEF_N_IN  = 4;
   localparam int DEF_N_OUT = 3;
   localparam int DEF_ET    = 3;

   // Sizes derived from the default geometry.
   localparam int VEC_COUNT = 1 << DEF_N_IN;
   localparam int SUM_W     = DEF_N_OUT + DEF_N_IN;
   localparam int CNT_W     = DEF_N_IN + 1;

   // Sweep controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } sweep_state_t;

   // Error sum can reach (2^n_out - 1) * 2^n_in, so n_out + n_in bits suffice.
   function automatic int sum_width(input int n_in, input int n_out);
      return n_out + n_in;
   endfunction

   // Mismatch count can reach 2^n_in, which needs one extra bit.
   function automatic int cnt_width(input int n_in);
      return n_in + 1;
   endfunction

endpackage

// File: rtl/approx_abs_err.sv
// Absolute difference of two unsigned N_OUT-bit values, plus a non-zero flag.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module approx_abs_err #(
   parameter int N_OUT = 3
) (
   input  logic [N_OUT-1:0] a,
   input  logic [N_OUT-1:0] b,
   output logic [N_OUT-1:0] mag,
   output logic             nz
);

   logic [N_OUT:0] diff;
   logic [N_OUT:0] mag_full;

   // Difference is one bit wider so the sign is never lost; negate when negative.
   assign diff     = {1'b0, a} - {1'b0, b};
   assign mag_full = diff[N_OUT] ? (~diff + 1'b1) : diff;
   assign mag      = mag_full[N_OUT-1:0];
   assign nz       = |diff;

endmodule

// File: rtl/approx_error_sweeper.sv
// Sweeps all 2^N_IN vectors through an exact/approx pair and accumulates error stats.
// Latency: done pulses 2^N_IN+1 cycles after start is sampled; one IDLE cycle between sweeps.
// Backpressure: none; start is ignored while sweeping or reporting.
module approx_error_sweeper
   import approx_eval_pkg::*;
#(
   parameter int N_IN  = DEF_N_IN,
   parameter int N_OUT = DEF_N_OUT,
   parameter int ET    = DEF_ET
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   output logic [N_IN-1:0]                   stim_o,
   input  logic [N_OUT-1:0]                  exact_i,
   input  logic [N_OUT-1:0]                  approx_i,
   output logic                              busy,
   output logic                              done,
   output logic [N_OUT-1:0]                  max_err,
   output logic [N_IN-1:0]                   worst_vec,
   output logic [cnt_width(N_IN)-1:0]        err_count,
   output logic [sum_width(N_IN, N_OUT)-1:0] err_sum,
   output logic                              pass
);

   localparam int SW = sum_width(N_IN, N_OUT);
   localparam int CW = cnt_width(N_IN);

   sweep_state_t     state;
   logic [N_OUT-1:0] cur_err;
   logic             cur_nz;

   approx_abs_err #(.N_OUT(N_OUT)) u_abs_err (
      .a   (exact_i),
      .b   (approx_i),
      .mag (cur_err),
      .nz  (cur_nz)
   );

   // Threshold check is inclusive and read straight off the held worst error.
   assign pass = (int'(max_err) <= ET);

   // Controller, stimulus counter and accumulators; all outputs registered here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         stim_o    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         max_err   <= '0;
         worst_vec <= '0;
         err_count <= '0;
         err_sum   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= ST_SWEEP;
                  busy      <= 1'b1;
                  stim_o    <= '0;
                  max_err   <= '0;
                  worst_vec <= '0;
                  err_count <= '0;
                  err_sum   <= '0;
               end
            end
            ST_SWEEP: begin
               // Strict compare so a tie keeps the earlier vector.
               if (cur_err > max_err) begin
                  max_err   <= cur_err;
                  worst_vec <= stim_o;
               end
               err_count <= err_count + CW'(cur_nz);
               err_sum   <= err_sum + SW'(cur_err);
               stim_o    <= stim_o + 1'b1;
               if (&stim_o) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_approx_error_sweeper.sv
module tb_approx_error_sweeper;
   import approx_eval_pkg::*;

   localparam int N_IN  = DEF_N_IN;
   localparam int N_OUT = DEF_N_OUT;
   localparam int ET    = DEF_ET;
   localparam int NV    = VEC_COUNT;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [N_IN-1:0]      stim_o;
   logic [N_OUT-1:0]     exact_i;
   logic [N_OUT-1:0]     approx_i;
   logic                 busy;
   logic                 done;
   logic [N_OUT-1:0]     max_err;
   logic [N_IN-1:0]      worst_vec;
   logic [CNT_W-1:0]     err_count;
   logic [SUM_W-1:0]     err_sum;
   logic                 pass;

   // Truth tables of the two circuits under evaluation.
   logic [N_OUT-1:0] ex_tab [NV];
   logic [N_OUT-1:0] ap_tab [NV];

   assign exact_i  = ex_tab[stim_o];
   assign approx_i = ap_tab[stim_o];

   approx_error_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stim_o    (stim_o),
      .exact_i   (exact_i),
      .approx_i  (approx_i),
      .busy      (busy),
      .done      (done),
      .max_err   (max_err),
      .worst_vec (worst_vec),
      .err_count (err_count),
      .err_sum   (err_sum),
      .pass      (pass)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     mx;
      int     worst;
      int     cnt;
      int     sum;
      int     pss;
      longint cyc;
   } exp_t;

   exp_t   sb_q[$];
   exp_t   mon_e;
   int     checks = 0;
   int     errors = 0;
   int     n_done = 0;
   longint cyc = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // Reference: walk every vector with plain integer arithmetic.
   function automatic exp_t ref_model();
      exp_t r;
      r.mx = 0; r.worst = 0; r.cnt = 0; r.sum = 0; r.cyc = 0;
      for (int v = 0; v < NV; v++) begin
         int d;
         d = int'(ex_tab[v]) - int'(ap_tab[v]);
         if (d < 0) d = -d;
         if (d > r.mx) begin
            r.mx    = d;
            r.worst = v;
         end
         if (d != 0) r.cnt++;
         r.sum += d;
      end
      r.pss = (r.mx <= ET) ? 1 : 0;
      return r;
   endfunction

   // Monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         n_done++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending sweep (cycle %0d)", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            chk("done_cycle", cyc, mon_e.cyc);
            chk("max_err", max_err, mon_e.mx);
            chk("worst_vec", worst_vec, mon_e.worst);
            chk("err_count", err_count, mon_e.cnt);
            chk("err_sum", err_sum, mon_e.sum);
            chk("pass", pass, mon_e.pss);
            chk("busy_at_done", busy, 0);
         end
      end
   end

   task automatic start_sweep(input bit push);
      exp_t r;
      @(negedge clk);
      if (push) begin
         r     = ref_model();
         r.cyc = cyc + 17;
         sb_q.push_back(r);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_dones(input int target, input int budget);
      int i;
      i = 0;
      while (n_done < target && i < budget) begin
         @(posedge clk);
         i++;
      end
      if (n_done < target) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got %0d done pulses expected %0d", n_done, target);
      end
   endtask

   task automatic run_sweep();
      int d0;
      d0 = n_done;
      start_sweep(1'b1);
      wait_dones(d0 + 1, 40);
   endtask

   initial begin
      exp_t r;
      longint c;
      int     d0;
      int     i;

      for (int v = 0; v < NV; v++) begin
         ex_tab[v] = '0;
         ap_tab[v] = '0;
      end

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_stim", stim_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_max_err", max_err, 0);
      chk("rst_worst_vec", worst_vec, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_err_sum", err_sum, 0);
      chk("rst_pass", pass, 1);
      rst_n = 1'b1;

      // Identical circuits.
      for (int v = 0; v < NV; v++) begin
         ex_tab[v] = N_OUT'(v);
         ap_tab[v] = N_OUT'(v);
      end
      run_sweep();

      // Low bit flipped everywhere.
      for (int v = 0; v < NV; v++) ap_tab[v] = ex_tab[v] ^ 3'b001;
      run_sweep();

      // Approximation stuck at zero: ties at 7 and 15 keep 7.
      for (int v = 0; v < NV; v++) ap_tab[v] = '0;
      run_sweep();

      // Approx above exact exercises the negative difference path.
      for (int v = 0; v < NV; v++) begin
         ex_tab[v] = '0;
         ap_tab[v] = 3'd7;
      end
      run_sweep();

      // Random truth tables.
      for (int t = 0; t < 8; t++) begin
         for (int v = 0; v < NV; v++) begin
            ex_tab[v] = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
            if ($urandom_range(0, 2) == 0) ap_tab[v] = ex_tab[v];
            else ap_tab[v] = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
         end
         run_sweep();
      end

      // Reset in the middle of a sweep: no done, everything cleared.
      for (int v = 0; v < NV; v++) begin
         ex_tab[v] = N_OUT'(v);
         ap_tab[v] = '0;
      end
      start_sweep(1'b0);
      i = 0;
      while (stim_o !== 4'd5 && i < 30) begin
         @(negedge clk);
         i++;
      end
      chk("mid_reset_reached_vec5", stim_o, 5);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_stim", stim_o, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_max_err", max_err, 0);
      chk("mid_rst_worst_vec", worst_vec, 0);
      chk("mid_rst_err_count", err_count, 0);
      chk("mid_rst_err_sum", err_sum, 0);
      chk("mid_rst_pass", pass, 1);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      run_sweep();

      // Start held high: back-to-back sweeps 18 cycles apart.
      for (int v = 0; v < NV; v++) begin
         ex_tab[v] = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
         ap_tab[v] = N_OUT'($urandom_range(0, (1 << N_OUT) - 1));
      end
      d0 = n_done;
      @(negedge clk);
      c = cyc;
      r = ref_model();
      r.cyc = c + 17;
      sb_q.push_back(r);
      r.cyc = c + 35;
      sb_q.push_back(r);
      start = 1'b1;
      repeat (8) @(negedge clk);
      chk("busy_held_start", busy, 1);
      repeat (28) @(negedge clk);
      start = 1'b0;
      wait_dones(d0 + 2, 60);

      repeat (25) @(negedge clk);
      chk("scoreboard_drained", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
